// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU byte protocol: widths, frame layout,
// FSM state encoding and ALU opcodes.
package uart_alu_pkg;

  localparam int N_DATA       = 8;
  localparam int NB_OPERATION = 6;

  // A request travels as three bytes in this fixed order.
  localparam int FRAME_BYTES  = 3;
  localparam int BYTE_IDX_A   = 0;
  localparam int BYTE_IDX_B   = 1;
  localparam int BYTE_IDX_OP  = 2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SEND_A   = 4'd1,
    WAIT_A   = 4'd2,
    SEND_B   = 4'd3,
    WAIT_B   = 4'd4,
    SEND_OP  = 4'd5,
    WAIT_OP  = 4'd6,
    WAIT_RSP = 4'd7,
    RESP     = 4'd8
  } state_t;

  localparam logic [NB_OPERATION-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OPERATION-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OPERATION-1:0] OP_AND = 6'h24;
  localparam logic [NB_OPERATION-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OPERATION-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OPERATION-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OPERATION-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OPERATION-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_requester_timeout_counter.sv
// Saturating cycle counter: o_expired rises after MAX-1 enabled increments
// since the last clear and stays high until cleared.
module timeout_counter #(
  parameter int MAX = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int               CNT_W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: state is updated only with non-blocking assignments, and the
  // synchronous reset is the first branch so it wins over every other action.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/uart_alu_requester.sv
// Host-side initiator: sends A, B, OP as three UART bytes, then waits for the
// one-byte ALU result or reports a timeout.
module uart_alu_requester #(
  parameter int N_DATA         = uart_alu_pkg::N_DATA,
  parameter int NB_OPERATION   = uart_alu_pkg::NB_OPERATION,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  input  logic [N_DATA-1:0]       i_req_a,
  input  logic [N_DATA-1:0]       i_req_b,
  input  logic [NB_OPERATION-1:0] i_req_op,
  output logic                    o_req_ready,
  output logic                    o_rsp_valid,
  output logic [N_DATA-1:0]       o_rsp_data,
  output logic                    o_rsp_timeout,
  output logic [N_DATA-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  input  logic [N_DATA-1:0]       i_rx_data,
  input  logic                    i_rx_done,
  output logic                    o_busy
);

  import uart_alu_pkg::*;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [N_DATA-1:0]       r_b;
  logic [NB_OPERATION-1:0] r_op;
  logic [N_DATA-1:0]       r_tx_data;
  logic [N_DATA-1:0]       r_rsp_data;
  logic                    r_rsp_timeout;
  logic                    w_accept;
  logic                    w_cnt_clear;
  logic                    w_cnt_enable;
  logic                    w_expired;

  assign w_accept = i_req_valid && (r_state == IDLE);

  timeout_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_enable = 1'b0;
    case (r_state)
      IDLE:     if (i_req_valid) w_next_state = SEND_A;
      SEND_A:   w_next_state = WAIT_A;
      WAIT_A:   if (i_tx_done) w_next_state = SEND_B;
      SEND_B:   w_next_state = WAIT_B;
      WAIT_B:   if (i_tx_done) w_next_state = SEND_OP;
      SEND_OP:  w_next_state = WAIT_OP;
      WAIT_OP: begin
        if (i_tx_done) begin
          w_next_state = WAIT_RSP;
          w_cnt_clear  = 1'b1;
        end
      end
      WAIT_RSP: begin
        w_cnt_enable = 1'b1;
        if (i_rx_done || w_expired) w_next_state = RESP;
      end
      RESP:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // The outgoing byte register is reloaded as each byte completes, so it
  // stays stable for the whole SEND/WAIT pair of that byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_b           <= '0;
      r_op          <= '0;
      r_tx_data     <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_data <= i_req_a;
        r_b       <= i_req_b;
        r_op      <= i_req_op;
      end
      if (r_state == WAIT_A && i_tx_done) r_tx_data <= r_b;
      if (r_state == WAIT_B && i_tx_done) r_tx_data <= N_DATA'(r_op);
      // A byte arriving on the expiry cycle still counts as the result.
      if (r_state == WAIT_RSP) begin
        if (i_rx_done) begin
          r_rsp_data    <= i_rx_data;
          r_rsp_timeout <= 1'b0;
        end else if (w_expired) begin
          r_rsp_data    <= '0;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_req_ready   = (r_state == IDLE);
  assign o_busy        = (r_state != IDLE);
  assign o_tx_start    = (r_state == SEND_A) || (r_state == SEND_B) || (r_state == SEND_OP);
  assign o_tx_data     = r_tx_data;
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/uart_alu_requester.md
Name: uart_alu_requester

Overview:
- Host-side initiator for the UART ALU byte protocol: the other end of the link served by uart_alu_interface.
- Accepts one operation (A, B, OP) on a valid/ready port and serialises it as three bytes through a uart_tx instance.
- Waits for the one-byte result from a uart_rx instance, then returns it, or flags a timeout.
- Used in loopback boards and as the stimulus engine of the system-level bench.

Parameters:
- N_DATA, 8, width of operand, result and UART byte.
- NB_OPERATION, 6, width of the ALU opcode.
- TIMEOUT_CYCLES, 1000000, i_clk cycles to wait for the result byte before giving up; must be >= 2.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-low (0 = reset).
- i_req_valid  input  1  request present.
- i_req_a  input  N_DATA  operand A.
- i_req_b  input  N_DATA  operand B.
- i_req_op  input  NB_OPERATION  ALU opcode.
- o_req_ready  output  1  block can accept a request (high only in IDLE).
- o_rsp_valid  output  1  one-cycle pulse: response available.
- o_rsp_data  output  N_DATA  result byte; held until the next response.
- o_rsp_timeout  output  1  qualifies o_rsp_valid: 1 = no result received, o_rsp_data = 0.
- o_tx_data  output  N_DATA  byte to uart_tx.
- o_tx_start  output  1  one-cycle start pulse to uart_tx.
- i_tx_done  input  1  uart_tx byte-complete pulse.
- i_rx_data  input  N_DATA  uart_rx byte.
- i_rx_done  input  1  uart_rx byte-valid pulse.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (i_rst=0 at a clock edge) forces:
  - state IDLE.
  - o_req_ready=1 from the first cycle after reset.
  - o_rsp_valid=0, o_rsp_timeout=0, o_rsp_data=0, o_tx_start=0, o_tx_data=0, o_busy=0.
  - timeout counter = 0.
- Reset mid-transaction aborts immediately. No response is produced. A uart_tx frame already in flight completes on its own; its i_tx_done is ignored because the block is in IDLE.
- Accept: i_req_valid && o_req_ready at edge N latches A, B and OP. OP is zero-extended to N_DATA.
- Wire order is fixed: byte0 = A, byte1 = B, byte2 = {zeros, OP}.
- FSM states: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RSP, RESP.
  - IDLE -> SEND_A on accept.
  - SEND_x: o_tx_data = byte, o_tx_start=1 for exactly one cycle, then WAIT_x. o_tx_data is held stable through WAIT_x.
  - WAIT_x: wait for i_tx_done, then go to the next SEND state. WAIT_OP -> WAIT_RSP; the timeout counter clears on entry.
  - WAIT_RSP, i_rx_done=1: capture i_rx_data into o_rsp_data, go to RESP with timeout flag 0.
  - WAIT_RSP, counter = TIMEOUT_CYCLES-1 and no i_rx_done: o_rsp_data=0, flag 1, go to RESP. Otherwise the counter increments.
  - RESP: o_rsp_valid=1 for one cycle, then IDLE.
- o_rsp_timeout is registered with o_rsp_valid and holds until the next response.
- Latency: first o_tx_start at N+1; o_rsp_valid exactly one cycle after the i_rx_done cycle; back to ready the cycle after o_rsp_valid.
- Simultaneous events:
  - i_rx_done on the same cycle the counter expires: the data wins, flag 0.
  - i_req_valid while busy: ignored, nothing is queued.
- Spurious pulses:
  - i_rx_done outside WAIT_RSP is discarded; a stray byte during the send phase is never taken as the result.
  - i_tx_done outside WAIT_x is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and never wraps.

Decomposition:
- Shared package uart_alu_pkg holds:
  - N_DATA, NB_OPERATION.
  - the wire byte-order constants (FRAME_BYTES=3, index of A/B/OP).
  - the FSM state localparams, shared with uart_alu_interface for bench decoding.
  - ALU opcode constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, NOR=6'h27, SRA=6'h03, SRL=6'h02).
- One natural sub-module: timeout_counter (clear, enable, expired output, parameter MAX). It is reused later by the rx watchdog.

Test Plan:
- Reset: drive i_rst=0 for 3 cycles with i_req_valid=1 -> all outputs 0 except o_req_ready=1; no o_tx_start.
- Basic: A=0x05, B=0x03, OP=ADD; bench UART model pulses i_tx_done 20 cycles after each start and answers rx 0x08 -> tx bytes 0x05, 0x03, 0x20 in order; o_rsp_valid one pulse with o_rsp_data=0x08, o_rsp_timeout=0; ready again next cycle.
- Timeout: TIMEOUT_CYCLES=64, no rx reply -> o_rsp_valid exactly 64 cycles after entering WAIT_RSP, flag=1, data=0x00.
- Race: TIMEOUT_CYCLES=64, i_rx_done=0xAA on the expiry cycle -> data=0xAA, flag=0.
- Stray and busy inputs: i_rx_done=0x55 during WAIT_B, plus a second request while busy -> 0x55 ignored; the second request is not accepted; the real result 0xF0 (A=0xF0, B=0xFF, OP=AND) is returned.
- Mid reset: i_rst=0 during WAIT_B -> IDLE next cycle, no o_rsp_valid; a new request (SUB 0x10, 0x01 -> 0x0F) then completes normally.
